// File: rtl/fanout_split_pipe.sv
// Registered broadcast of one word to NUM_CH channels through a bounded-fanout repeater tree, plus a long delay path.
// Latency din->ch_q is L+2, din->long_q is LONG_DEPTH+2; one word per cycle, no backpressure.
module fanout_split_pipe #(
  parameter int WIDTH       = 1,
  parameter int NUM_CH      = 16,
  parameter int TREE_FANOUT = 4,
  parameter int LONG_DEPTH  = 5,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        din,
  input  logic                    din_valid,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH*WIDTH-1:0] ch_q,
  output logic [NUM_CH-1:0]       ch_valid,
  output logic [WIDTH-1:0]        long_q,
  output logic                    long_valid,
  output logic                    busy,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        deliver_cnt
);

  function automatic int ipow(input int b, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  function automatic int tree_depth(input int n, input int f);
    int l;
    int p;
    l = 1;
    p = f;
    while (p < n) begin
      p = p * f;
      l++;
    end
    return l;
  endfunction

  localparam int L = tree_depth(NUM_CH, TREE_FANOUT);

  function automatic int lvl_cnt(input int k);
    int d;
    d = ipow(TREE_FANOUT, L - k);
    return (NUM_CH + d - 1) / d;
  endfunction

  function automatic int lvl_off(input int k);
    int o;
    o = 0;
    for (int i = 1; i < k; i++) o = o + lvl_cnt(i);
    return o;
  endfunction

  // Node j of level k hangs off node j/TREE_FANOUT of level k-1 (only called for k>1).
  function automatic int node_parent(input int n);
    int k;
    k = 1;
    while (n >= lvl_off(k + 1)) k++;
    return lvl_off(k - 1) + (n - lvl_off(k)) / TREE_FANOUT;
  endfunction

  localparam int TOT   = lvl_off(L + 1);
  localparam int OFF_L = lvl_off(L);
  localparam int CNT1  = lvl_cnt(1);

  logic [WIDTH-1:0]  src_dat_q;
  logic              src_vld_q;
  logic [WIDTH-1:0]  tree_dat_q [TOT];
  logic [TOT-1:0]    tree_vld_q;
  logic [WIDTH-1:0]  par_dat    [TOT];
  logic [TOT-1:0]    par_vld;
  logic [WIDTH-1:0]  ch_dat_q   [NUM_CH];
  logic [NUM_CH-1:0] ch_vld_q;
  logic [NUM_CH-1:0] cap_d;
  logic [WIDTH-1:0]  long_dat_q [LONG_DEPTH+1];
  logic [LONG_DEPTH:0] long_vld_q;
  logic [WIDTH-1:0]  long_cap_q;
  logic              long_cap_vld_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      src_dat_q <= '0;
      src_vld_q <= 1'b0;
    end else begin
      src_vld_q <= din_valid;
      if (din_valid) src_dat_q <= din;
    end
  end

  for (genvar n = 0; n < TOT; n++) begin : g_node
    if (n < CNT1) begin : g_root
      assign par_dat[n] = src_dat_q;
      assign par_vld[n] = src_vld_q;
    end else begin : g_inner
      localparam int P = node_parent(n);
      assign par_dat[n] = tree_dat_q[P];
      assign par_vld[n] = tree_vld_q[P];
    end
  end

  // Data registers load only with a valid word so idle cycles do not toggle the tree.
  always_ff @(posedge clk) begin
    if (rst) begin
      tree_vld_q <= '0;
      for (int n = 0; n < TOT; n++) tree_dat_q[n] <= '0;
    end else begin
      tree_vld_q <= par_vld;
      for (int n = 0; n < TOT; n++) begin
        if (par_vld[n]) tree_dat_q[n] <= par_dat[n];
      end
    end
  end

  assign cap_d = tree_vld_q[OFF_L +: NUM_CH] & ch_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_vld_q <= '0;
      for (int i = 0; i < NUM_CH; i++) ch_dat_q[i] <= '0;
    end else begin
      ch_vld_q <= cap_d;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap_d[i]) ch_dat_q[i] <= tree_dat_q[OFF_L + i];
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_q[i*WIDTH +: WIDTH] = ch_dat_q[i];
  end
  assign ch_valid = ch_vld_q;

  // Stage 0 is a private copy of the source register so the tree root keeps its load bound.
  always_ff @(posedge clk) begin
    if (rst) begin
      long_vld_q     <= '0;
      long_cap_vld_q <= 1'b0;
      long_cap_q     <= '0;
      for (int s = 0; s <= LONG_DEPTH; s++) long_dat_q[s] <= '0;
    end else begin
      long_vld_q[0] <= din_valid;
      if (din_valid) long_dat_q[0] <= din;
      for (int s = 1; s <= LONG_DEPTH; s++) begin
        long_vld_q[s] <= long_vld_q[s-1];
        if (long_vld_q[s-1]) long_dat_q[s] <= long_dat_q[s-1];
      end
      long_cap_vld_q <= long_vld_q[LONG_DEPTH];
      if (long_vld_q[LONG_DEPTH]) long_cap_q <= long_dat_q[LONG_DEPTH];
    end
  end

  assign long_q     = long_cap_q;
  assign long_valid = long_cap_vld_q;
  assign busy       = src_vld_q | (|tree_vld_q) | (|long_vld_q);

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (tree_vld_q[OFF_L] && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign deliver_cnt = cnt_q;

endmodule

// File: tb/tb_fanout_split_pipe.sv
// Directed bench: default instance, a 4-bit-counter instance, and six geometry instances share one stimulus stream.
module tb_fanout_split_pipe;

  logic        clk;
  logic        rst;
  logic [0:0]  din;
  logic        din_valid;
  logic [15:0] ch_en;
  logic        cnt_clr;

  logic [15:0] ch_q, ch_valid, deliver_cnt;
  logic [0:0]  long_q;
  logic        long_valid, busy;

  logic [15:0] c_ch_q, c_ch_valid;
  logic [0:0]  c_long_q;
  logic        c_long_valid, c_busy;
  logic [3:0]  c_cnt;

  logic [5:0]  sw_all, sw_any, sw_qall, sw_aux;
  int          sw_l [6] = '{1, 3, 5, 1, 2, 3};

  int n_chk  = 0;
  int n_fail = 0;

  fanout_split_pipe #(.WIDTH(1), .NUM_CH(16), .TREE_FANOUT(4), .LONG_DEPTH(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .ch_en(ch_en),
    .ch_q(ch_q), .ch_valid(ch_valid), .long_q(long_q), .long_valid(long_valid),
    .busy(busy), .cnt_clr(cnt_clr), .deliver_cnt(deliver_cnt)
  );

  fanout_split_pipe #(.WIDTH(1), .NUM_CH(16), .TREE_FANOUT(4), .LONG_DEPTH(5), .CNT_W(4)) cdut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .ch_en(ch_en),
    .ch_q(c_ch_q), .ch_valid(c_ch_valid), .long_q(c_long_q), .long_valid(c_long_valid),
    .busy(c_busy), .cnt_clr(cnt_clr), .deliver_cnt(c_cnt)
  );

  for (genvar g = 0; g < 6; g++) begin : g_sw
    localparam int NC = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 5 : 17);
    localparam int FO = (g < 3) ? 2 : 4;
    logic [NC-1:0] v, qv;
    logic [0:0]    lq;
    logic          lv, bz;
    logic [15:0]   dc;
    fanout_split_pipe #(.WIDTH(1), .NUM_CH(NC), .TREE_FANOUT(FO), .LONG_DEPTH(5), .CNT_W(16)) u_sw (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .ch_en({NC{1'b1}}),
      .ch_q(qv), .ch_valid(v), .long_q(lq), .long_valid(lv),
      .busy(bz), .cnt_clr(cnt_clr), .deliver_cnt(dc)
    );
    assign sw_all[g]  = &v;
    assign sw_any[g]  = |v;
    assign sw_qall[g] = &qv;
    assign sw_aux[g]  = lv | bz | (|dc) | lq[0];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_chq;
    logic        exp_lq;
    int          m;

    rst = 1'b1; din = 1'b1; din_valid = 1'b1; ch_en = 16'hFFFF; cnt_clr = 1'b0;
    tick();
    tick();
    chk("rst_ch_q", ch_q, 0);
    chk("rst_ch_valid", ch_valid, 0);
    chk("rst_long_q", long_q, 0);
    chk("rst_long_valid", long_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", deliver_cnt, 0);

    rst = 1'b0; din_valid = 1'b0; din = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("idle_ch_valid", ch_valid, 0);
      chk("idle_long_valid", long_valid, 0);
    end

    // Single word: channels at +4, long path at +7, geometry instances at +L+2.
    for (int k = 0; k < 10; k++) begin
      din_valid = (k == 0); din = 1'b1;
      tick();
      m = k + 1;
      chk("lat_busy", busy, (m <= 6) ? 1 : 0);
      chk("lat_ch_valid", ch_valid, (m == 4) ? 16'hFFFF : 16'h0000);
      chk("lat_long_valid", long_valid, (m == 7) ? 1 : 0);
      if (m == 4) begin
        chk("lat_ch_q", ch_q, 16'hFFFF);
        chk("lat_cnt", deliver_cnt, 1);
      end
      if (m == 7) chk("lat_long_q", long_q, 1);
      for (int g = 0; g < 6; g++) begin
        chk("sweep_all", sw_all[g], (m == sw_l[g] + 2) ? 1 : 0);
        chk("sweep_any", sw_any[g], (m == sw_l[g] + 2) ? 1 : 0);
        if (m == sw_l[g] + 2) chk("sweep_q", sw_qall[g], 1);
      end
    end

    ch_en = 16'h00F0;
    for (int k = 0; k < 8; k++) begin
      din_valid = (k < 2); din = (k == 0);
      tick();
      m = k + 1;
      chk("mask_ch_valid", ch_valid, (m == 4 || m == 5) ? 16'h00F0 : 16'h0000);
      chk("mask_ch_q", ch_q, (m <= 4) ? 16'hFFFF : 16'hFF0F);
      if (m == 7) chk("mask_long_q1", long_q, 1);
      if (m == 8) chk("mask_long_q0", long_q, 0);
    end
    chk("mask_cnt", deliver_cnt, 3);

    cnt_clr = 1'b1; din_valid = 1'b0;
    tick();
    cnt_clr = 1'b0;
    chk("clr_cnt", deliver_cnt, 0);
    chk("clr_c_cnt", c_cnt, 0);

    ch_en = 16'h00FF;
    exp_chq = 16'hFF0F;
    exp_lq = 1'b0;
    for (int k = 0; k < 108; k++) begin
      din_valid = (k < 100); din = ((k % 2) == 0);
      tick();
      m = k + 1;
      if (m >= 4 && m <= 103) exp_chq = {8'hFF, (((m - 4) % 2) == 0) ? 8'hFF : 8'h00};
      if (m >= 7 && m <= 106) exp_lq = (((m - 7) % 2) == 0);
      chk("str_ch_valid", ch_valid, (m >= 4 && m <= 103) ? 16'h00FF : 16'h0000);
      chk("str_ch_q", ch_q, exp_chq);
      chk("str_long_valid", long_valid, (m >= 7 && m <= 106) ? 1 : 0);
      chk("str_long_q", long_q, exp_lq);
      if (m == 17) chk("sat_c_cnt14", c_cnt, 14);
      if (m == 30) chk("sat_c_cnt15", c_cnt, 15);
      if (m == 23) chk("str_cnt20", deliver_cnt, 20);
    end
    chk("str_cnt100", deliver_cnt, 100);
    chk("str_c_cnt", c_cnt, 15);
    chk("str_busy", busy, 0);

    // cnt_clr coincides with the first delivery of a two-word burst.
    for (int k = 0; k < 6; k++) begin
      din_valid = (k < 2); din = 1'b1; cnt_clr = (k == 3);
      tick();
      m = k + 1;
      if (m == 4) begin
        chk("clrwin_cnt", deliver_cnt, 0);
        chk("clrwin_c_cnt", c_cnt, 0);
      end
      if (m >= 5) begin
        chk("clrnext_cnt", deliver_cnt, 1);
        chk("clrnext_c_cnt", c_cnt, 1);
      end
    end
    cnt_clr = 1'b0;

    for (int k = 0; k < 16; k++) begin
      din_valid = (k < 3); din = 1'b1; rst = (k == 2);
      tick();
      m = k + 1;
      if (m == 2) chk("mid_busy_pre", busy, 1);
      if (m >= 3) begin
        chk("mid_ch_valid", ch_valid, 0);
        chk("mid_long_valid", long_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_cnt", deliver_cnt, 0);
      end
      if (m == 3) begin
        chk("mid_ch_q", ch_q, 0);
        chk("mid_long_q", long_q, 0);
        chk("mid_c_outs", {c_ch_q, c_ch_valid, c_long_q, c_long_valid, c_busy, c_cnt}, 0);
      end
      if (m == 15) chk("mid_sweep_aux", sw_aux, 0);
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fanout_split_pipe.md
Name: fanout_split_pipe

Overview:
- Parametrised registered high-fanout distribution block.
- One WIDTH-bit source register broadcasts to NUM_CH capture channels through a pipelined repeater tree; each tree register drives at most TREE_FANOUT loads.
- A separate long-path channel delays the same word through LONG_DEPTH extra register stages.
- Sits between a single producing flop and many consuming flops; provides a bounded-load, timing-clean structure for resizer split-load and repair-setup evaluation.

Parameters:
WIDTH, 1, data bits per word.
NUM_CH, 16, number of broadcast capture channels (>=1).
TREE_FANOUT, 4, maximum loads driven by any source or tree register (>=2).
LONG_DEPTH, 5, extra register stages on the long-path channel (>=1).
CNT_W, 16, width of the delivered-word counter.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
din  in  WIDTH  word to broadcast.
din_valid  in  1  din accepted on every cycle this is high (no backpressure).
ch_en  in  NUM_CH  per-channel capture enable.
ch_q  out  NUM_CH*WIDTH  channel capture registers; channel i at bits [i*WIDTH +: WIDTH].
ch_valid  out  NUM_CH  per-channel one-cycle capture pulse.
long_q  out  WIDTH  long-path capture register.
long_valid  out  1  long-path one-cycle capture pulse.
busy  out  1  high while any word is in flight.
cnt_clr  in  1  clears deliver_cnt.
deliver_cnt  out  CNT_W  count of words reaching the tree output.

Behaviour:
- Reset: all data, valid, ch_q, ch_valid, long_q, long_valid, busy and deliver_cnt registers go to 0.
  - rst has priority over all other inputs.
  - In-flight words are discarded.
  - No valid pulse appears after rst deasserts until a new din_valid.
- Tree depth L: smallest L>=1 with TREE_FANOUT^L >= NUM_CH. Defaults give L=2.
  - Each level has ceil(NUM_CH / TREE_FANOUT^(L-k)) replicated registers, each with a valid bit.
  - No register exceeds TREE_FANOUT loads.
- Latency:
  - din_valid high in cycle T → src valid in T+1 → ch_q/ch_valid visible in cycle T+L+2 (T+4 at defaults).
  - Long path: long_q/long_valid visible in T+LONG_DEPTH+2 (T+7 at defaults).
- Throughput: one word per cycle, no stalls. Back-to-back words keep order and produce consecutive valid pulses.
- Enabled channel: ch_en[i] is sampled in the cycle the word is at the last tree level.
  - If 1: ch_q[i] loads the word and ch_valid[i] pulses.
  - If 0: ch_q[i] holds its old value and ch_valid[i]=0.
- Long path: ignores ch_en; always captures.
- Idle cycles (din_valid=0): valid bits are 0, and ch_q/long_q hold their values. Data registers also hold, to avoid toggling.
- busy = OR of the src, tree and long-stage valid bits (registered stages only). busy is 0 in the cycle after the last long-path capture pulse.
- deliver_cnt:
  - Increments by 1 when the last tree level holds a valid word, regardless of ch_en.
  - Saturates at 2^CNT_W-1.
  - cnt_clr sets it to 0. If cnt_clr and an increment occur in the same cycle, cnt_clr wins and the increment is dropped.
- No combinational path from any input to any output.

Test Plan:
- Reset: rst for 2 cycles with din_valid=1, din=1 → all outputs 0; after release with din_valid=0, no ch_valid/long_valid pulse for 20 cycles.
- Latency (defaults): single din=1, din_valid pulse in cycle 10, ch_en=all 1s →
  - all 16 ch_valid pulse in cycle 14 with ch_q=all 1s;
  - long_valid pulses in cycle 17 with long_q=1;
  - busy high in cycles 11-16, low from cycle 17.
- Masking: ch_en=16'h00F0, word 1 then word 0 back-to-back →
  - channels 4-7 pulse on two consecutive cycles, ending with ch_q=0;
  - other channels show no pulse and hold their prior value.
- Streaming: 100 consecutive words, alternating 1/0, WIDTH=1 → every enabled channel and the long path reproduce the sequence in order, with no gaps; deliver_cnt=100.
- Counter: CNT_W=4, stream 20 words → deliver_cnt saturates at 15. Then assert cnt_clr in the same cycle as a delivery → 0 the next cycle, and 1 after the following delivery.
- Mid-flight reset: 3 words injected, rst asserted 2 cycles later for 1 cycle → no ch_valid/long_valid pulses afterward, busy=0, deliver_cnt=0.
- Geometry sweep: NUM_CH=1, 5, 17 with TREE_FANOUT=2, 4 → L is 1, 3, 5 and 1, 2, 3; measured latency = L+2 in every configuration.
